// File: rtl/apb_rr_arbiter.sv
// Round-robin arbiter giving NUM_REQ requesters one APB master port. A zero-wait transfer returns rsp_vld 3 cycles after the request is seen.
// Requests are held until their rsp_vld. The slave stalls through b_pready, and a watchdog aborts ACCESS phases that never complete.
module apb_rr_arbiter #(
   parameter int NUM_REQ     = 2,
   parameter int ADDR_WD     = 32,
   parameter int DATA_WD     = 32,
   parameter int STRB_WD     = 4,
   parameter int PROT_WD     = 3,
   parameter int TIMEOUT_CYC = 64
) (
   input  logic                         b_pclk,
   input  logic                         b_prst_n,
   input  logic [NUM_REQ-1:0]           req_vld,
   input  logic [NUM_REQ-1:0]           req_write,
   input  logic [NUM_REQ*ADDR_WD-1:0]   req_addr,
   input  logic [NUM_REQ*DATA_WD-1:0]   req_wdata,
   input  logic [NUM_REQ*STRB_WD-1:0]   req_strb,
   input  logic [NUM_REQ*PROT_WD-1:0]   req_prot,
   output logic [NUM_REQ-1:0]           rsp_vld,
   output logic [DATA_WD-1:0]           rsp_rdata,
   output logic                         rsp_err,
   output logic [$clog2(NUM_REQ)-1:0]   grant_id,
   output logic                         busy,
   output logic                         b_psel,
   output logic                         b_penable,
   output logic                         b_pwrite,
   output logic [ADDR_WD-1:0]           b_paddr,
   output logic [DATA_WD-1:0]           b_pwdata,
   output logic [STRB_WD-1:0]           b_pstrb,
   output logic [PROT_WD-1:0]           b_pprot,
   input  logic [DATA_WD-1:0]           b_prdata,
   input  logic                         b_pready
);

   localparam int GW   = $clog2(NUM_REQ);
   localparam int WD_W = (TIMEOUT_CYC < 1) ? 1 : $clog2(TIMEOUT_CYC + 1);

   typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_ACCESS} state_t;

   state_t               state_q, state_d;
   logic [GW-1:0]        ptr_q, ptr_d, gid_q, gid_d;
   logic [WD_W-1:0]      wd_cnt_q, wd_cnt_d;
   logic                 psel_q, psel_d, penable_q, penable_d, pwrite_q, pwrite_d;
   logic [ADDR_WD-1:0]   paddr_q, paddr_d;
   logic [DATA_WD-1:0]   pwdata_q, pwdata_d;
   logic [STRB_WD-1:0]   pstrb_q, pstrb_d;
   logic [PROT_WD-1:0]   pprot_q, pprot_d;
   logic [NUM_REQ-1:0]   rsp_vld_q, rsp_vld_d;
   logic [DATA_WD-1:0]   rsp_rdata_q, rsp_rdata_d;
   logic                 rsp_err_q, rsp_err_d, busy_q, busy_d;
   logic [NUM_REQ-1:0]   elig;
   logic                 win_vld, wd_expire;
   logic [GW-1:0]        win_idx;

   assign wd_expire = (TIMEOUT_CYC != 0) && (wd_cnt_q == WD_W'(TIMEOUT_CYC));

   // A requester being answered this cycle still holds req_vld, so it sits out this arbitration round.
   always_comb begin
      int idx;
      elig    = req_vld & ~rsp_vld_q;
      win_vld = 1'b0;
      win_idx = '0;
      idx     = 0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx = (int'(ptr_q) + k) % NUM_REQ;
         if (!win_vld && elig[idx[GW-1:0]]) begin
            win_vld = 1'b1;
            win_idx = idx[GW-1:0];
         end
      end
   end

   always_ff @(posedge b_pclk) begin
      if (!b_prst_n) begin
         state_q     <= ST_IDLE;
         ptr_q       <= GW'(NUM_REQ - 1);
         gid_q       <= '0;
         wd_cnt_q    <= '0;
         psel_q      <= 1'b0;
         penable_q   <= 1'b0;
         pwrite_q    <= 1'b0;
         paddr_q     <= '0;
         pwdata_q    <= '0;
         pstrb_q     <= '0;
         pprot_q     <= '0;
         rsp_vld_q   <= '0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         gid_q       <= gid_d;
         wd_cnt_q    <= wd_cnt_d;
         psel_q      <= psel_d;
         penable_q   <= penable_d;
         pwrite_q    <= pwrite_d;
         paddr_q     <= paddr_d;
         pwdata_q    <= pwdata_d;
         pstrb_q     <= pstrb_d;
         pprot_q     <= pprot_d;
         rsp_vld_q   <= rsp_vld_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
         busy_q      <= busy_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   if (win_vld) state_d = ST_SETUP;
         ST_SETUP:  state_d = ST_ACCESS;
         ST_ACCESS: if (b_pready || wd_expire) state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      ptr_d       = ptr_q;
      gid_d       = gid_q;
      wd_cnt_d    = wd_cnt_q;
      pwrite_d    = pwrite_q;
      paddr_d     = paddr_q;
      pwdata_d    = pwdata_q;
      pstrb_d     = pstrb_q;
      pprot_d     = pprot_q;
      rsp_vld_d   = '0;
      rsp_rdata_d = rsp_rdata_q;
      rsp_err_d   = rsp_err_q;
      psel_d      = (state_d != ST_IDLE);
      penable_d   = (state_d == ST_ACCESS);
      busy_d      = (state_d != ST_IDLE);
      case (state_q)
         ST_IDLE: begin
            if (win_vld) begin
               ptr_d    = win_idx;
               gid_d    = win_idx;
               pwrite_d = req_write[win_idx];
               paddr_d  = req_addr[win_idx*ADDR_WD +: ADDR_WD];
               pwdata_d = req_wdata[win_idx*DATA_WD +: DATA_WD];
               pstrb_d  = req_strb[win_idx*STRB_WD +: STRB_WD];
               pprot_d  = req_prot[win_idx*PROT_WD +: PROT_WD];
               wd_cnt_d = '0;
            end
         end
         ST_SETUP: wd_cnt_d = WD_W'(1);
         ST_ACCESS: begin
            // A ready slave on the final watchdog cycle still completes normally.
            if (b_pready) begin
               rsp_vld_d[gid_q] = 1'b1;
               rsp_rdata_d      = pwrite_q ? '0 : b_prdata;
               rsp_err_d        = 1'b0;
               wd_cnt_d         = '0;
            end else if (wd_expire) begin
               rsp_vld_d[gid_q] = 1'b1;
               rsp_rdata_d      = '0;
               rsp_err_d        = 1'b1;
               wd_cnt_d         = '0;
            end else if (TIMEOUT_CYC != 0) begin
               wd_cnt_d = wd_cnt_q + 1'b1;
            end
         end
         default: ;
      endcase
   end

   assign rsp_vld   = rsp_vld_q;
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_err   = rsp_err_q;
   assign grant_id  = gid_q;
   assign busy      = busy_q;
   assign b_psel    = psel_q;
   assign b_penable = penable_q;
   assign b_pwrite  = pwrite_q;
   assign b_paddr   = paddr_q;
   assign b_pwdata  = pwdata_q;
   assign b_pstrb   = pstrb_q;
   assign b_pprot   = pprot_q;

endmodule

// File: tb/tb_apb_rr_arbiter.sv
// Bench for apb_rr_arbiter. A transaction-level model predicts grant order, phase timing and responses into queues.
// A separate negedge monitor pops those queues and compares them with what the DUT drives.
module tb_apb_rr_arbiter;
   localparam int N  = 3;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int SW = 4;
   localparam int PW = 3;
   localparam int TO = 4;
   localparam int GW = $clog2(N);

   typedef struct {
      int            cyc;
      int            id;
      logic          wr;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      logic [SW-1:0] strb;
      logic [PW-1:0] prot;
      int            rsp_cyc;
   } apb_exp_t;

   typedef struct {
      int            cyc;
      int            id;
      logic [DW-1:0] rdata;
      logic          err;
   } rsp_exp_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [N-1:0]  req_vld = '0, req_write = '0;
   logic [N*AW-1:0] req_addr = '0;
   logic [N*DW-1:0] req_wdata = '0;
   logic [N*SW-1:0] req_strb = '0;
   logic [N*PW-1:0] req_prot = '0;
   logic [N-1:0]  rsp_vld;
   logic [DW-1:0] rsp_rdata;
   logic          rsp_err, busy, psel, penable, pwrite;
   logic [GW-1:0] grant_id;
   logic [AW-1:0] paddr;
   logic [DW-1:0] pwdata;
   logic [SW-1:0] pstrb;
   logic [PW-1:0] pprot;
   logic [DW-1:0] prdata = '0;
   logic          pready = 1'b0;

   apb_rr_arbiter #(.NUM_REQ(N), .ADDR_WD(AW), .DATA_WD(DW), .STRB_WD(SW),
                    .PROT_WD(PW), .TIMEOUT_CYC(TO)) dut (
      .b_pclk(clk), .b_prst_n(rst_n),
      .req_vld(req_vld), .req_write(req_write), .req_addr(req_addr),
      .req_wdata(req_wdata), .req_strb(req_strb), .req_prot(req_prot),
      .rsp_vld(rsp_vld), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .grant_id(grant_id), .busy(busy),
      .b_psel(psel), .b_penable(penable), .b_pwrite(pwrite),
      .b_paddr(paddr), .b_pwdata(pwdata), .b_pstrb(pstrb), .b_pprot(pprot),
      .b_prdata(prdata), .b_pready(pready)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   apb_exp_t apb_q[$];
   rsp_exp_t rsp_q[$];
   int       rst_q[$];

   int checks = 0;
   int failures = 0;

   // model state: pointer, when the bus is next free, who is being answered, slave schedule
   int            m_ptr = N - 1, m_free = 0, m_rsp_cyc = -1, m_rsp_id = 0;
   int            m_owner = -1, m_own_end = 0, m_pr_cyc = -1, m_acc_lo = 0, m_acc_hi = 0;
   logic [DW-1:0] m_rdata = '0;
   int            force_w = -1;

   bit act[N];
   bit rnd_en = 1'b0, hold_en = 1'b0, tb_done = 1'b0;
   int nrsp = 0, drain_fail = 0;

   task automatic chk(string name, logic [63:0] got, logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, got, exp);
      end
   endtask

   task automatic set_req(int i, logic wr, logic [AW-1:0] a, logic [DW-1:0] d,
                          logic [SW-1:0] s, logic [PW-1:0] p);
      req_write[i]            = wr;
      req_addr[i*AW +: AW]    = a;
      req_wdata[i*DW +: DW]   = d;
      req_strb[i*SW +: SW]    = s;
      req_prot[i*PW +: PW]    = p;
      req_vld[i]              = 1'b1;
      act[i]                  = 1'b1;
   endtask

   task automatic rnd_req(int i);
      set_req(i, 1'($urandom), $urandom, $urandom, 4'($urandom), 3'($urandom));
   endtask

   task automatic update();
      for (int i = 0; i < N; i++) begin
         bit granted;
         granted = (m_owner == i) && (cyc < m_own_end);
         if (act[i] && rsp_vld[i] === 1'b1) begin
            act[i] = 1'b0;
            nrsp++;
            if (hold_en || (rnd_en && ($urandom % 3) == 0)) rnd_req(i);
            else req_vld[i] = 1'b0;
         end else if (rnd_en) begin
            if (!act[i] && ($urandom % 4) == 0) rnd_req(i);
            else if (act[i] && !granted && ($urandom % 8) == 0) rnd_req(i);
            else if (act[i] && granted && ($urandom % 10) == 0) req_vld[i] = 1'b0;
         end
      end
   endtask

   // Outside the model's ACCESS window pready and prdata are noise the DUT must ignore.
   task automatic drive_slave();
      if (cyc >= m_acc_lo && cyc < m_acc_hi) pready = (cyc == m_pr_cyc);
      else pready = 1'($urandom);
      prdata = (cyc == m_pr_cyc) ? m_rdata : $urandom;
   endtask

   task automatic model();
      if (!rst_n) begin
         while (apb_q.size() > 0 && apb_q[$].cyc > cyc) void'(apb_q.pop_back());
         while (rsp_q.size() > 0 && rsp_q[$].cyc > cyc) void'(rsp_q.pop_back());
         rst_q.push_back(cyc + 1);
         m_ptr = N - 1; m_free = cyc + 1; m_rsp_cyc = -1; m_owner = -1;
         m_pr_cyc = -1; m_acc_lo = 0; m_acc_hi = 0;
         for (int i = 0; i < N; i++) if (!req_vld[i]) act[i] = 1'b0;
      end else if (cyc >= m_free) begin
         int win;
         win = -1;
         for (int k = 1; k <= N; k++) begin
            int j;
            j = (m_ptr + k) % N;
            if (win < 0 && req_vld[j] && !(cyc == m_rsp_cyc && j == m_rsp_id)) win = j;
         end
         if (win >= 0) begin
            int w, nacc;
            apb_exp_t a;
            rsp_exp_t r;
            if (force_w >= 0) w = force_w;
            else w = (($urandom % 2) == 0) ? 0 : int'($urandom_range(1, TO + 1));
            force_w = -1;
            nacc    = (w < TO) ? w + 1 : TO;
            m_rdata = $urandom;
            a.cyc = cyc + 1; a.id = win; a.wr = req_write[win];
            a.addr = req_addr[win*AW +: AW]; a.wdata = req_wdata[win*DW +: DW];
            a.strb = req_strb[win*SW +: SW]; a.prot = req_prot[win*PW +: PW];
            a.rsp_cyc = cyc + 2 + nacc;
            r.cyc = cyc + 2 + nacc; r.id = win; r.err = (w >= TO);
            r.rdata = (req_write[win] || w >= TO) ? '0 : m_rdata;
            apb_q.push_back(a);
            rsp_q.push_back(r);
            m_pr_cyc = (w < TO) ? cyc + 2 + w : -1;
            m_acc_lo = cyc + 2; m_acc_hi = cyc + 2 + nacc;
            m_free = cyc + 2 + nacc; m_rsp_cyc = m_free; m_rsp_id = win;
            m_ptr = win; m_owner = win; m_own_end = m_free;
         end
      end
   endtask

   task automatic tick();
      update();
      drive_slave();
      model();
      @(negedge clk);
   endtask

   function automatic bit pending();
      bit p;
      p = (apb_q.size() > 0) || (rsp_q.size() > 0);
      for (int i = 0; i < N; i++) p = p || act[i];
      return p;
   endfunction

   task automatic wait_idle(int bound);
      int n;
      n = 0;
      while (pending() && n < bound) begin
         tick();
         n++;
      end
      if (pending()) drain_fail++;
   endtask

   initial begin
      int base, n;
      @(negedge clk);
      repeat (3) tick();
      rst_n = 1'b1;
      set_req(0, 1'b0, 32'h0000_0010, 32'h0, 4'h0, 3'h0);
      force_w = 0;
      wait_idle(40);

      hold_en = 1'b1;
      rnd_req(0);
      rnd_req(1);
      base = nrsp;
      n = 0;
      while (nrsp < base + 4 && n < 100) begin
         tick();
         n++;
      end
      if (nrsp < base + 4) drain_fail++;
      hold_en = 1'b0;
      wait_idle(60);

      set_req(1, 1'b1, 32'hC000_0004, 32'hDEAD_BEEF, 4'b0011, 3'b010);
      force_w = 3;
      wait_idle(40);

      set_req(0, 1'b0, 32'h0000_0100, 32'h0, 4'hF, 3'h1);
      force_w = TO + 1;
      wait_idle(40);
      set_req(1, 1'b0, 32'h0000_0200, 32'h0, 4'hF, 3'h0);
      force_w = 0;
      wait_idle(40);

      set_req(0, 1'b0, 32'h0000_0300, 32'h0, 4'hF, 3'h0);
      force_w = TO - 1;
      wait_idle(40);

      set_req(1, 1'b0, 32'h0000_0400, 32'h0, 4'hF, 3'h0);
      force_w = TO + 1;
      repeat (3) tick();
      rst_n = 1'b0;
      set_req(0, 1'b1, 32'h0000_0500, 32'h1234_5678, 4'hC, 3'h4);
      tick();
      rst_n = 1'b1;
      wait_idle(60);

      rnd_en = 1'b1;
      repeat (1500) begin
         if (($urandom % 400) == 0) rst_n = 1'b0;
         tick();
         rst_n = 1'b1;
      end
      rnd_en = 1'b0;
      wait_idle(300);
      tb_done = 1'b1;
   end

   apb_exp_t      cur;
   rsp_exp_t      rcur;
   bit            cur_v = 1'b0, mon_en = 1'b0;
   int            last_gid = 0;
   logic [DW-1:0] last_rd = '0;
   logic          last_err = 1'b0;

   initial begin
      forever begin
         @(negedge clk);
         if (tb_done) begin
            chk("drain_complete", 64'(drain_fail), 64'd0);
            chk("queues_empty", 64'(apb_q.size() + rsp_q.size()), 64'd0);
            $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
            $finish;
         end
         if (rst_q.size() > 0 && rst_q[0] == cyc) begin
            void'(rst_q.pop_front());
            mon_en = 1'b1; cur_v = 1'b0; last_gid = 0; last_rd = '0; last_err = 1'b0;
            chk("rst_psel", psel, 0);
            chk("rst_penable", penable, 0);
            chk("rst_pwrite", pwrite, 0);
            chk("rst_paddr", paddr, 0);
            chk("rst_pwdata", pwdata, 0);
            chk("rst_pstrb", pstrb, 0);
            chk("rst_pprot", pprot, 0);
            chk("rst_rsp_vld", rsp_vld, 0);
            chk("rst_rsp_rdata", rsp_rdata, 0);
            chk("rst_rsp_err", rsp_err, 0);
            chk("rst_busy", busy, 0);
            chk("rst_grant_id", grant_id, 0);
         end
         if (mon_en) begin
            bit es, os, er, orr, inwin;
            es = (apb_q.size() > 0) && (apb_q[0].cyc == cyc);
            os = (psel === 1'b1) && (penable === 1'b0);
            chk("setup_phase", os, es);
            if (es) begin
               cur = apb_q.pop_front();
               cur_v = 1'b1;
               last_gid = cur.id;
            end
            inwin = cur_v && cyc >= cur.cyc && cyc < cur.rsp_cyc;
            chk("psel", psel, inwin);
            chk("penable", penable, inwin && cyc > cur.cyc);
            chk("busy", busy, inwin);
            if (inwin) begin
               chk("pwrite", pwrite, cur.wr);
               chk("paddr", paddr, cur.addr);
               chk("pwdata", pwdata, cur.wdata);
               chk("pstrb", pstrb, cur.strb);
               chk("pprot", pprot, cur.prot);
            end
            chk("grant_id", grant_id, last_gid);
            er  = (rsp_q.size() > 0) && (rsp_q[0].cyc == cyc);
            orr = (rsp_vld !== '0);
            chk("rsp_pulse", orr, er);
            if (er) begin
               rcur = rsp_q.pop_front();
               last_rd = rcur.rdata;
               last_err = rcur.err;
               chk("rsp_vld_id", rsp_vld, 64'd1 << rcur.id);
            end
            chk("rsp_rdata", rsp_rdata, last_rd);
            chk("rsp_err", rsp_err, last_err);
         end
      end
   end

endmodule
